// File: rtl/regfile_sb.sv
// Register file with NRD combinational read ports, two write ports and a pending-write scoreboard.
// Reads are zero latency with same-cycle bypass from both write ports; state updates on the rising edge.
module regfile_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  w0_en,
  input  logic [ADDR_W-1:0]     w0_addr,
  input  logic [DATA_W-1:0]     w0_data,
  input  logic                  w1_en,
  input  logic [ADDR_W-1:0]     w1_addr,
  input  logic [DATA_W-1:0]     w1_data,
  input  logic                  rsv_en,
  input  logic [ADDR_W-1:0]     rsv_addr,
  input  logic                  flush,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_busy,
  output logic [ADDR_W:0]       busy_cnt,
  output logic                  wcollide
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [NREG];
  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   busy_nxt;
  logic [ADDR_W:0]   cnt_nxt;

  // A reservation wins over a same-cycle late-write clear; flush overrides both.
  always_comb begin
    busy_nxt = busy;
    if (flush) begin
      busy_nxt = '0;
    end else begin
      if (w1_en) busy_nxt[w1_addr] = 1'b0;
      if (rsv_en) busy_nxt[rsv_addr] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
    cnt_nxt = '0;
    for (int i = 0; i < NREG; i++) begin
      cnt_nxt = cnt_nxt + (ADDR_W+1)'(busy_nxt[i]);
    end
  end

  // Port 0 is assigned last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
      busy     <= '0;
      busy_cnt <= '0;
      wcollide <= 1'b0;
    end else begin
      if (w1_en && w1_addr != '0) mem[w1_addr] <= w1_data;
      if (w0_en && w0_addr != '0) mem[w0_addr] <= w0_data;
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
      wcollide <= w0_en && w1_en && (w0_addr == w1_addr) && (w0_addr != '0);
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic              hit0;
    logic              hit1;
    assign a    = rd_addr[k*ADDR_W +: ADDR_W];
    assign hit0 = rst && w0_en && (w0_addr == a);
    assign hit1 = rst && w1_en && (w1_addr == a);
    assign rd_data[k*DATA_W +: DATA_W] = (a == '0) ? '0 :
                                         hit0      ? w0_data :
                                         hit1      ? w1_data : mem[a];
    assign rd_busy[k] = busy[a] && !hit1;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised general-purpose register file with N combinational read ports, two write ports and a per-register pending-write scoreboard. It sits in the decode stage of the CPU. Port 0 takes pipeline write-back; port 1 takes late results from the multiply/divide unit and out-of-band loads. The scoreboard marks registers whose value is still owed by a long-latency unit, so decode can stall on `rd_busy` instead of reading stale data.

## Interface
- `DATA_W`, 32, register width
- `ADDR_W`, 5, address width; the file holds 2^ADDR_W registers, and register 0 is hard-wired to zero
- `NRD`, 4, number of read ports
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  reset, synchronous, active-low
- `w0_en`  in  1  write port 0 enable (pipeline write-back)
- `w0_addr`  in  ADDR_W  write port 0 address
- `w0_data`  in  DATA_W  write port 0 data
- `w1_en`  in  1  write port 1 enable (late unit); also clears the scoreboard bit
- `w1_addr`  in  ADDR_W  write port 1 address
- `w1_data`  in  DATA_W  write port 1 data
- `rsv_en`  in  1  reserve destination: sets the busy bit
- `rsv_addr`  in  ADDR_W  register to reserve
- `flush`  in  1  clear all busy bits (exception/redirect)
- `rd_addr`  in  NRD*ADDR_W  read addresses; port k at bits [k*ADDR_W +: ADDR_W]
- `rd_data`  out  NRD*DATA_W  read data, packed the same way
- `rd_busy`  out  NRD  per-port flag: the register is still owed by the late unit
- `busy_cnt`  out  ADDR_W+1  number of busy bits currently set
- `wcollide`  out  1  registered, one-cycle pulse: both write ports hit the same nonzero address in the previous cycle

## Operation
- **Register 0**
  - Writes to register 0 are discarded.
  - Reads of register 0 return 0 with `rd_busy`=0.
  - `rsv_addr`=0 is ignored.
- **Write priority:** if `w0` and `w1` target the same nonzero address in the same cycle, `w0_data` is stored and `wcollide` pulses the next cycle. The `w1` scoreboard clear still takes effect.
- **Read port k, combinational, in priority order**
  - Address 0 returns 0.
  - Else `w0_en` and `w0_addr` match: return `w0_data`.
  - Else `w1_en` and `w1_addr` match: return `w1_data`.
  - Else return the stored value.
- **`rd_busy[k]`** = `busy[addr_k]` AND NOT (`w1_en` AND `w1_addr`==`addr_k`). A same-cycle late write is bypassed, so it is not reported busy. A reservation in the current cycle is not yet visible.
- **Busy bit update per register r, priority high to low**
  - `flush`: clear all bits; `rsv_en` is ignored this cycle.
  - `rsv_en` and `rsv_addr`==r: set. This wins over a same-cycle `w1` clear of r.
  - `w1_en` and `w1_addr`==r: clear.
  - Otherwise hold.
- **Idempotence:** reserving an already-busy register leaves it busy, with no count change. A `w1` write to a non-busy register is a plain write.
- **`busy_cnt`:** registered population count of the busy vector. It always equals the number of set bits after the edge; it is maintained incrementally or recomputed, and the value must match either way.
- **Scope:** there is no hi/lo state in this block; hi/lo stays separate.

## Timing
- **Reset**
  - On a rising edge with `rst`=0: all registers, busy bits, `busy_cnt` and `wcollide` go to 0.
  - While `rst`=0, writes, reservations and bypass are suppressed, so every `rd_data` lane reads 0 and `rd_busy`=0 after the first reset edge.
  - Reset asserted mid-operation discards pending reservations. No write is committed on that edge.
- **Latencies**
  - A write on edge t is visible from storage at cycle t+1.
  - The same-cycle value is available through bypass with zero latency.
  - A reservation on edge t is visible in `rd_busy` and `busy_cnt` at cycle t+1.
  - A `w1` clear is visible in `rd_busy` combinationally the same cycle, and in `busy_cnt` at t+1.
- **Read paths:** all `rd_data`/`rd_busy` paths are combinational from `rd_addr` and the write ports. There is no read enable.
- **`busy_cnt` range:** cannot exceed 2^ADDR_W - 1, because register 0 is never busy.

## Test plan
- **Reset:** write r5=0x1234 via `w0`, reserve r6, then assert `rst` for one edge -> all `rd_data`=0, `rd_busy`=0, `busy_cnt`=0.
- **Bypass and write priority:** `w0` r3=0xAAAA0000 and `w1` r3=0x5555FFFF in the same cycle, all four read ports on r3 -> same cycle `rd_data`=0xAAAA0000 on every port; next cycle storage holds 0xAAAA0000 and `wcollide`=1 for exactly one cycle.
- **Scoreboard lifecycle:** reserve r8 at edge t -> `rd_busy`=1 and `busy_cnt`=1 at t+1. `w1` r8=0xDEADBEEF at cycle t+3 -> `rd_busy`=0 and `rd_data`=0xDEADBEEF in that cycle; `busy_cnt`=0 at t+4.
- **Simultaneous reserve and clear of r9:** -> r9 stays busy and `busy_cnt` unchanged. Reserve r0 -> ignored, `busy_cnt` unchanged.
- **Flush:** reserve r1..r31 one per cycle -> `busy_cnt`=31. Assert `flush` together with `rsv_en` r4 -> `busy_cnt`=0 next cycle and r4 not busy.
- **Parameter sweep:** `NRD`=2, `ADDR_W`=3, `DATA_W`=16 -> r7 write and read round-trip; `busy_cnt` saturates at 7 with all of r1..r7 reserved.
